dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory interface. Accepts one load/store request
//  at a time, identified by the MIPS opcode (ins[31:26]). Services it after a fixed

---
 rtl/dm_pkg.sv | 32 +++
 rtl/dm_lane_ctrl.sv | 64 ++++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared opcodes, FSM states and request payload for the data-memory responder.
package dm_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dm_req_t;

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Big-endian byte-lane steering: write enables/data, load extract/extend, alignment check.
module dm_lane_ctrl
    import dm_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wword,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign,
    output logic              bad_op
);

    logic [4:0]  shamt;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Byte 0 lives in [31:24], so the right-shift amount is 8*(3-addr_lo).
    assign shamt  = {~addr_lo, 3'b000};
    assign byte_v = 8'(rword >> shamt);
    assign half_v = addr_lo[1] ? rword[15:0] : rword[31:16];

    always_comb begin
        be       = 4'b0000;
        wword    = '0;
        rdata    = '0;
        misalign = 1'b0;
        bad_op   = 1'b0;
        case (op)
            OP_LB:  rdata = {{24{byte_v[7]}}, byte_v};
            OP_LBU: rdata = {24'b0, byte_v};
            OP_LH: begin
                misalign = addr_lo[0];
                rdata    = {{16{half_v[15]}}, half_v};
            end
            OP_LHU: begin
                misalign = addr_lo[0];
                rdata    = {16'b0, half_v};
            end
            OP_LW: begin
                misalign = |addr_lo;
                rdata    = rword;
            end
            OP_SB: begin
                be    = 4'b1000 >> addr_lo;
                wword = {4{wdata[7:0]}};
            end
            OP_SH: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b0011 : 4'b1100;
                wword    = {2{wdata[15:0]}};
            end
            OP_SW: begin
                misalign = |addr_lo;
                be       = 4'b1111;
                wword    = wdata;
            end
            default: bad_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: fixed-latency access to a byte-lane RAM behind
// valid/ready request and response handshakes.
module dmem_responder
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    dm_req_t           req_in;
    dm_req_t           req_q;
    dm_req_t           acc;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] widx;
    logic [DATA_W-1:0] rword;
    logic [3:0]        be;
    logic [DATA_W-1:0] wword;
    logic [DATA_W-1:0] ld_data;
    logic              misalign;
    logic              bad_op;
    logic              range_err;
    logic              err;
    logic              accept;
    logic              fire;
    logic              we;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_in    = '{op: req_op, addr: req_addr, wdata: req_wdata};

    // With single-cycle latency the access happens on the accept edge itself.
    assign acc = (LATENCY == 1) ? req_in : req_q;

    assign widx      = acc.addr[ADDR_W+1:2];
    assign rword     = mem[widx];
    assign range_err = (acc.addr >> (ADDR_W + 2)) != '0;
    assign err       = misalign | bad_op | range_err;

    assign fire = !rst && ((LATENCY == 1) ? accept
                                          : (state == ST_WAIT && cnt == CNT_W'(1)));
    assign we   = fire && is_store(acc.op) && !err;

    dm_lane_ctrl u_lane (
        .op       (acc.op),
        .addr_lo  (acc.addr[1:0]),
        .wdata    (acc.wdata),
        .rword    (rword),
        .be       (be),
        .wword    (wword),
        .rdata    (ld_data),
        .misalign (misalign),
        .bad_op   (bad_op)
    );

    // Request latch; contents only matter while a transaction is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q <= req_in;
        end
    end

    // RAM with per-lane writes, committed on the RESP entry edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (fire) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || is_store(acc.op)) ? '0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;
    import dm_pkg::*;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mb [int unsigned];

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: memory as individual bytes, big-endian assembly, arithmetic sign extension.
    function automatic void model(input logic [5:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic er);
        int     size;
        bit     sgn;
        bit     st;
        bit     ok;
        longint v;
        size = 4; sgn = 0; st = 0; ok = 1;
        case (op)
            6'b100000: begin size = 1; sgn = 1; end
            6'b100001: begin size = 2; sgn = 1; end
            6'b100011: size = 4;
            6'b100100: size = 1;
            6'b100101: size = 2;
            6'b101000: begin size = 1; st = 1; end
            6'b101001: begin size = 2; st = 1; end
            6'b101011: begin size = 4; st = 1; end
            default:   ok = 0;
        endcase
        rd = '0;
        er = !ok || (longint'(addr) % size) != 0 || longint'(addr) >= (longint'(4) << ADDR_W);
        if (er) return;
        if (st) begin
            for (int k = 0; k < size; k++)
                mb[addr + k] = 8'(wdata >> (8 * (size - 1 - k)));
        end else begin
            v = 0;
            for (int k = 0; k < size; k++)
                v = (v << 8) | longint'(mb.exists(addr + k) ? mb[addr + k] : 8'h00);
            if (sgn && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            rd = 32'(v);
        end
    endfunction

    task automatic txn(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        logic [31:0] er;
        logic        ee;
        int          cyc;
        model(op, addr, wdata, er, ee);
        cyc = 0;
        while (!req_ready && cyc < 40) begin @(negedge clk); cyc++; end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
        check("latency", 32'(cyc), 32'(LATENCY));
        check("rdata", rsp_rdata, er);
        check("err", 32'(rsp_err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            // A competing request while the response is parked must be ignored.
            req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, er);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] op;
        logic [31:0] addr;
        int cyc;
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'b000000, 6'b100010};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int w = 0; w < 64; w++) txn(OP_SW, 32'(w * 4), $urandom, 0);

        txn(OP_SW,  32'h10, 32'h11223344, 0);
        txn(OP_LW,  32'h10, 32'h0, 0);
        txn(OP_LB,  32'h13, 32'h0, 0);
        txn(OP_SW,  32'h10, 32'h80FF0000, 0);
        txn(OP_LB,  32'h10, 32'h0, 0);
        txn(OP_LBU, 32'h10, 32'h0, 0);
        txn(OP_LH,  32'h12, 32'h0, 0);
        txn(OP_LHU, 32'h10, 32'h0, 0);
        txn(OP_SW,  32'h20, 32'h00000000, 0);
        txn(OP_SB,  32'h21, 32'h000000AA, 0);
        txn(OP_LW,  32'h20, 32'h0, 0);
        txn(OP_SH,  32'h22, 32'h0000BEEF, 0);
        txn(OP_LW,  32'h20, 32'h0, 0);
        txn(OP_LW,  32'h11, 32'h0, 0);
        txn(OP_SH,  32'h23, 32'h00001234, 0);
        txn(OP_LW,  32'h20, 32'h0, 0);
        txn(OP_LW,  32'h00010000, 32'h0, 0);
        txn(6'b000000, 32'h20, 32'h0, 0);
        txn(OP_LW,  32'h10, 32'h0, 5);
        txn(OP_LW,  32'h0, 32'h0, 0);

        // Reset while a store is still waiting: it must never reach the RAM.
        txn(OP_SW, 32'h40, 32'h01234567, 0);
        cyc = 0;
        while (!req_ready && cyc < 40) begin @(negedge clk); cyc++; end
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(OP_LW, 32'h40, 32'h0, 0);

        for (int i = 0; i < 250; i++) begin
            op = ops[$urandom_range(0, 9)];
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
            txn(op, addr, $urandom, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
